// File: rtl/pr_shutdown_axis_term.sv
// AXI4-Stream terminator placed between a reconfigurable partition and static logic.
// Optional build macro PR_SHUTDOWN_AXIS_TERM_TUSER_ERR_EN sets tuser to all ones on the forced TERM beat.
module pr_shutdown_axis_term #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 1,
    parameter int unsigned C_TIMEOUT_CYCLES   = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            shutdown_req,
    output logic                            shutdown_ack,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready
);

    localparam int unsigned              CNT_W    = $clog2(C_TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(C_TIMEOUT_CYCLES - 1);
`ifdef PR_SHUTDOWN_AXIS_TERM_TUSER_ERR_EN
    localparam logic [C_AXIS_TUSER_WIDTH-1:0] TERM_TUSER = '1;
`else
    localparam logic [C_AXIS_TUSER_WIDTH-1:0] TERM_TUSER = '0;
`endif

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TERM  = 2'd2,
        SHUT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_in_packet;
    logic [CNT_W-1:0]   r_idle_cnt;
    logic               r_ack;

    logic               w_pass;
    logic               w_accept;
    logic               w_timeout;

    assign w_pass    = (r_state == RUN) || (r_state == DRAIN);
    assign w_accept  = w_pass && s_axis_tvalid && m_axis_tready;
    assign w_timeout = (r_idle_cnt == CNT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN: begin
                if (shutdown_req) begin
                    if (w_accept && s_axis_tlast)
                        w_next = SHUT;
                    else if (!r_in_packet && !w_accept)
                        w_next = SHUT;
                    else
                        w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_accept && s_axis_tlast)
                    w_next = SHUT;
                else if (!shutdown_req)
                    w_next = RUN;
                else if (w_timeout && !s_axis_tvalid)
                    w_next = TERM;
            end
            TERM: begin
                if (m_axis_tready)
                    w_next = SHUT;
            end
            SHUT: begin
                if (!shutdown_req)
                    w_next = RUN;
            end
            default: w_next = SHUT;
        endcase
    end

    // Ack is registered from the next state so it is high exactly while the state register is SHUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SHUT;
            r_ack   <= 1'b1;
        end else begin
            r_state <= w_next;
            r_ack   <= (w_next == SHUT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_in_packet <= 1'b0;
        else if (!w_pass)
            r_in_packet <= 1'b0;
        else if (w_accept)
            r_in_packet <= !s_axis_tlast;
    end

    // Zero outside DRAIN, so every DRAIN entry starts from a clean count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_idle_cnt <= '0;
        else if ((r_state != DRAIN) || w_accept)
            r_idle_cnt <= '0;
        else if (!s_axis_tvalid)
            r_idle_cnt <= r_idle_cnt + 1'b1;
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        case (r_state)
            RUN, DRAIN: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tuser  = s_axis_tuser;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
            end
            TERM: begin
                m_axis_tkeep  = '1;
                m_axis_tuser  = TERM_TUSER;
                m_axis_tlast  = 1'b1;
                m_axis_tvalid = 1'b1;
            end
            SHUT: begin
                s_axis_tready = 1'b1;
            end
            default: begin
                s_axis_tready = 1'b0;
            end
        endcase
    end

    assign shutdown_ack = r_ack;

endmodule

// File: tb/tb_pr_shutdown_axis_term.sv
// Directed self-checking bench for pr_shutdown_axis_term (32-bit data, 1-bit tuser, 16-cycle timeout).
module tb_pr_shutdown_axis_term;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int UW = 1;
`ifdef PR_SHUTDOWN_AXIS_TERM_TUSER_ERR_EN
    localparam logic [UW-1:0] EXP_TUSER = '1;
`else
    localparam logic [UW-1:0] EXP_TUSER = '0;
`endif
    localparam logic [38:0] TERM_BUS = {1'b1, 32'h0, 4'hF, EXP_TUSER, 1'b1};

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          ack;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [38:0]   m_bus;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign m_bus = {m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast};

    pr_shutdown_axis_term #(
        .C_AXIS_TDATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .C_TIMEOUT_CYCLES   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .shutdown_req  (req),
        .shutdown_ack  (ack),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] d, input logic [3:0] k, input logic u, input logic l);
        s_tdata  = d;
        s_tkeep  = k;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
    endtask

    task automatic set_idle;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 1'b0;
        m_tready = 1'b0;
        set_beat(32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1);
        tick;
        tick;
        total++;
        if (m_bus !== 39'h0) begin
            bad++;
            $display("FAIL reset_m_bus: got %h want %h", m_bus, 39'h0);
        end
        total++;
        if ({s_tready, ack} !== 2'b11) begin
            bad++;
            $display("FAIL reset_tready_ack: got %b want %b", {s_tready, ack}, 2'b11);
        end
        rst = 1'b0;
        set_idle;
        m_tready = 1'b1;
        #1;
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ack: got %b want %b", ack, 1'b1);
        end
        tick;
        total++;
        if ({ack, s_tready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_run_entry: got %b want %b", {ack, s_tready}, 2'b01);
        end
        m_tready = 1'b0;
        #1;
        total++;
        if (s_tready !== 1'b0) begin
            bad++;
            $display("FAIL run_tready_follow: got %b want %b", s_tready, 1'b0);
        end
        m_tready = 1'b1;
        tick;
    endtask

    task automatic test_idle_shutdown;
        set_idle;
        req = 1'b1;
        #1;
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL idle_ack_pre_edge: got %b want %b", ack, 1'b0);
        end
        tick;
        total++;
        if ({ack, s_tready, m_tvalid} !== 3'b110) begin
            bad++;
            $display("FAIL idle_shut: got %b want %b", {ack, s_tready, m_tvalid}, 3'b110);
        end
        set_beat(32'h1234_5678, 4'hF, 1'b1, 1'b1);
        #1;
        total++;
        if (m_bus !== 39'h0 || s_tready !== 1'b1) begin
            bad++;
            $display("FAIL shut_discard: got bus=%h rdy=%b want bus=%h rdy=1", m_bus, s_tready, 39'h0);
        end
        tick;
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL shut_hold: got %b want %b", ack, 1'b1);
        end
        req = 1'b0;
        set_idle;
        tick;
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL shut_to_run: got %b want %b", ack, 1'b0);
        end
    endtask

    task automatic test_drain_complete;
        logic [31:0] d;
        logic [3:0]  k;
        m_tready = 1'b1;
        req = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) req = 1'b1;
            d = 32'hA5A5_0000 | 32'(i);
            k = (i == 8) ? 4'h3 : 4'hF;
            set_beat(d, k, i[0], (i == 8));
            #1;
            total++;
            if (m_bus !== {1'b1, d, k, i[0], (i == 8)} || s_tready !== 1'b1 || ack !== 1'b0) begin
                bad++;
                $display("FAIL drain_beat%0d: got bus=%h rdy=%b ack=%b want bus=%h rdy=1 ack=0",
                         i, m_bus, s_tready, ack, {1'b1, d, k, i[0], (i == 8)});
            end
            tick;
        end
        set_idle;
        #1;
        total++;
        if ({ack, m_tvalid} !== 2'b10) begin
            bad++;
            $display("FAIL drain_shut_after_last: got %b want %b", {ack, m_tvalid}, 2'b10);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            total++;
            if ({ack, m_tvalid} !== 2'b10) begin
                bad++;
                $display("FAIL drain_no_term_beat%0d: got %b want %b", c, {ack, m_tvalid}, 2'b10);
            end
        end
        req = 1'b0;
        tick;
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL drain_back_to_run: got %b want %b", ack, 1'b0);
        end
    endtask

    task automatic test_last_beat_shutdown;
        m_tready = 1'b1;
        req = 1'b0;
        set_beat(32'h5555_0001, 4'hF, 1'b0, 1'b0);
        tick;
        req = 1'b1;
        set_beat(32'h5555_0002, 4'h1, 1'b1, 1'b1);
        #1;
        total++;
        if (m_bus !== {1'b1, 32'h5555_0002, 4'h1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL lastbeat_pass: got %h want %h", m_bus, {1'b1, 32'h5555_0002, 4'h1, 1'b1, 1'b1});
        end
        tick;
        set_idle;
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL lastbeat_shut: got %b want %b", ack, 1'b1);
        end
        req = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        m_tready = 1'b1;
        req = 1'b0;
        set_beat(32'hC0DE_0001, 4'hF, 1'b0, 1'b0);
        tick;
        req = 1'b1;
        set_beat(32'hC0DE_0002, 4'hF, 1'b0, 1'b0);
        tick;
        set_idle;
        for (int c = 1; c <= 15; c++) begin
            tick;
            total++;
            if ({m_tvalid, s_tready, ack} !== 3'b010) begin
                bad++;
                $display("FAIL timeout_idle%0d: got %b want %b", c, {m_tvalid, s_tready, ack}, 3'b010);
            end
        end
        tick;
        total++;
        if (m_bus !== TERM_BUS || s_tready !== 1'b0 || ack !== 1'b0) begin
            bad++;
            $display("FAIL timeout_term_beat: got bus=%h rdy=%b ack=%b want bus=%h rdy=0 ack=0",
                     m_bus, s_tready, ack, TERM_BUS);
        end
        tick;
        total++;
        if (m_bus !== 39'h0 || ack !== 1'b1) begin
            bad++;
            $display("FAIL timeout_single_beat: got bus=%h ack=%b want bus=%h ack=1", m_bus, ack, 39'h0);
        end
        req = 1'b0;
        tick;
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL timeout_back_to_run: got %b want %b", ack, 1'b0);
        end
    endtask

    task automatic test_term_backpressure;
        m_tready = 1'b1;
        req = 1'b1;
        set_beat(32'h0BAD_0001, 4'hF, 1'b0, 1'b0);
        tick;
        set_idle;
        m_tready = 1'b0;
        repeat (5) tick;
        set_beat(32'h0BAD_0002, 4'hF, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if ({m_tvalid, s_tready} !== 2'b10) begin
                bad++;
                $display("FAIL bp_drain_stall%0d: got %b want %b", c, {m_tvalid, s_tready}, 2'b10);
            end
            tick;
        end
        set_idle;
        for (int c = 1; c <= 10; c++) begin
            tick;
            total++;
            if ({m_tvalid, ack} !== 2'b00) begin
                bad++;
                $display("FAIL bp_drain_idle%0d: got %b want %b", c, {m_tvalid, ack}, 2'b00);
            end
        end
        tick;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (m_bus !== TERM_BUS || s_tready !== 1'b0 || ack !== 1'b0) begin
                bad++;
                $display("FAIL bp_term_hold%0d: got bus=%h rdy=%b ack=%b want bus=%h rdy=0 ack=0",
                         c, m_bus, s_tready, ack, TERM_BUS);
            end
            if (c == 1) begin
                req = 1'b0;
                set_beat(32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0);
            end
            tick;
        end
        set_idle;
        m_tready = 1'b1;
        #1;
        total++;
        if (m_bus !== TERM_BUS) begin
            bad++;
            $display("FAIL bp_term_handshake: got %h want %h", m_bus, TERM_BUS);
        end
        tick;
        total++;
        if (m_bus !== 39'h0 || s_tready !== 1'b1 || ack !== 1'b1) begin
            bad++;
            $display("FAIL bp_shut_entry: got bus=%h rdy=%b ack=%b want bus=%h rdy=1 ack=1",
                     m_bus, s_tready, ack, 39'h0);
        end
        tick;
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL bp_back_to_run: got %b want %b", ack, 1'b0);
        end
    endtask

    task automatic test_drain_abort;
        logic [31:0] d;
        m_tready = 1'b1;
        req = 1'b0;
        set_beat(32'hAB00_0001, 4'hF, 1'b0, 1'b0);
        tick;
        req = 1'b1;
        set_beat(32'hAB00_0002, 4'hF, 1'b0, 1'b0);
        tick;
        set_idle;
        repeat (7) tick;
        total++;
        if ({m_tvalid, s_tready, ack} !== 3'b010) begin
            bad++;
            $display("FAIL abort_drain_cnt7: got %b want %b", {m_tvalid, s_tready, ack}, 3'b010);
        end
        req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick;
            total++;
            if ({m_tvalid, s_tready, ack} !== 3'b010) begin
                bad++;
                $display("FAIL abort_run_idle%0d: got %b want %b", c, {m_tvalid, s_tready, ack}, 3'b010);
            end
        end
        req = 1'b1;
        tick;
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL abort_in_packet_kept: got %b want %b", ack, 1'b0);
        end
        req = 1'b0;
        tick;
        for (int i = 3; i <= 5; i++) begin
            d = 32'hAB00_0000 | 32'(i);
            set_beat(d, 4'hF, 1'b0, (i == 5));
            #1;
            total++;
            if (m_bus !== {1'b1, d, 4'hF, 1'b0, (i == 5)} || s_tready !== 1'b1) begin
                bad++;
                $display("FAIL abort_beat%0d: got bus=%h rdy=%b want bus=%h rdy=1",
                         i, m_bus, s_tready, {1'b1, d, 4'hF, 1'b0, (i == 5)});
            end
            tick;
        end
        set_idle;
        req = 1'b1;
        tick;
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL abort_idle_shut: got %b want %b", ack, 1'b1);
        end
        req = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_packet;
        logic [31:0] d;
        m_tready = 1'b1;
        req = 1'b0;
        set_beat(32'hBEEF_0001, 4'hF, 1'b0, 1'b0);
        tick;
        set_beat(32'hBEEF_0002, 4'hF, 1'b0, 1'b0);
        tick;
        set_beat(32'hBEEF_0003, 4'hF, 1'b1, 1'b0);
        #1;
        total++;
        if (m_tvalid !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre: got %b want %b", m_tvalid, 1'b1);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (m_bus !== 39'h0 || s_tready !== 1'b1 || ack !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_async: got bus=%h rdy=%b ack=%b want bus=%h rdy=1 ack=1",
                     m_bus, s_tready, ack, 39'h0);
        end
        tick;
        set_idle;
        rst = 1'b0;
        tick;
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_run: got %b want %b", ack, 1'b0);
        end
        req = 1'b1;
        tick;
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_in_packet_cleared: got %b want %b", ack, 1'b1);
        end
        req = 1'b0;
        tick;
        for (int i = 1; i <= 4; i++) begin
            d = 32'h7700_0000 | 32'(i);
            set_beat(d, (i == 4) ? 4'h7 : 4'hF, i[0], (i == 4));
            #1;
            total++;
            if (m_bus !== {1'b1, d, ((i == 4) ? 4'h7 : 4'hF), i[0], (i == 4)} || ack !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_next_beat%0d: got bus=%h ack=%b want bus=%h ack=0",
                         i, m_bus, ack, {1'b1, d, ((i == 4) ? 4'h7 : 4'hF), i[0], (i == 4)});
            end
            tick;
        end
        set_idle;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_idle_shutdown;
        test_drain_complete;
        test_last_beat_shutdown;
        test_timeout;
        test_term_backpressure;
        test_drain_abort;
        test_reset_mid_packet;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
